// File: rtl/serial_adder_n_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_adder_n_if.sv
// Start/busy/done handshake and operand/result bundle.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n_fa_cell.sv
// One-bit full adder; chained to form the per-cycle ripple slice.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, registered carry.
module serial_adder_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic             clk,
  input logic             rst,
  serial_adder_n_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad
    $error("serial_adder_n: DIGIT must divide WIDTH, WIDTH >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] ds;
  logic [WIDTH-1:0] acc_nx;
  logic             last;

  assign c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa_cell u_fa (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (c[i]),
      .s  (ds[i]),
      .co (c[i+1])
    );
  end

  // Digit sums enter at the MSB end so the first digit lands at bit 0.
  if (STEPS == 1) begin : g_one
    assign acc_nx = ds;
  end else begin : g_many
    assign acc_nx = {ds, acc_q[WIDTH-1:DIGIT]};
  end

  assign last = (cnt_q == CW'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_nx;
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = acc_nx;
          cout_d  = c[DIGIT];
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: 8/1 and 16/4 instances against an arithmetic model.
module tb_serial_adder_n;
  logic clk = 1'b0;
  logic rst8, rst16;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  serial_adder_n_if #(.WIDTH(8))  if8 ();
  serial_adder_n_if #(.WIDTH(16)) if16 ();

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8.slave)
  );

  serial_adder_n #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (if16.slave)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Signed/unsigned arithmetic reference, independent of carry chains.
  function automatic void model(input int w, input longint ua0,
                                input longint ub0, input bit sub,
                                input bit cin, output longint s,
                                output bit co, output bit ov);
    longint m, ua, ub, sa, sb, t, ex;
    m  = 64'sd1 << w;
    ua = ua0 & (m - 1);
    ub = ub0 & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      t  = ua - ub;
      s  = ((t % m) + m) % m;
      co = (ua >= ub);
      ex = sa - sb;
    end else begin
      t  = ua + ub + longint'(cin);
      s  = t % m;
      co = (t >= m);
      ex = sa + sb + longint'(cin);
    end
    ov = (ex < -(m / 2)) || (ex >= m / 2);
  endfunction

  task automatic drv(input bit sel, input bit st, input logic [15:0] a,
                     input logic [15:0] b, input bit cin, input bit sub);
    if (sel) begin
      if16.start = st; if16.a = a; if16.b = b;
      if16.cin = cin;  if16.sub = sub;
    end else begin
      if8.start = st; if8.a = a[7:0]; if8.b = b[7:0];
      if8.cin = cin;  if8.sub = sub;
    end
  endtask

  // Returns in the cycle where done is seen (sampled 1 after the edge).
  task automatic op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                    input bit cin, input bit sub, input int poke,
                    input string tag, output logic [15:0] os,
                    output logic oc, output logic ov);
    longint es;
    bit     ec, eo;
    int     n, w, lat;
    bit     held, bz;
    logic [15:0] prev;
    w    = sel ? 16 : 8;
    lat  = sel ? 5 : 9;
    model(w, longint'(a), longint'(b), sub, cin, es, ec, eo);
    prev = sel ? if16.sum : {8'h00, if8.sum};
    held = 1'b1;
    bz   = 1'b1;
    drv(sel, 1'b1, a, b, cin, sub);
    @(posedge clk); #1;
    n = 1;
    drv(sel, 1'b0, a, b, cin, sub);
    while (!(sel ? if16.done : if8.done) && n < 40) begin
      if (!(sel ? if16.busy : if8.busy)) bz = 1'b0;
      if ((sel ? if16.sum : {8'h00, if8.sum}) !== prev) held = 1'b0;
      if (n == poke) drv(sel, 1'b1, ~a, ~b, ~cin, ~sub);
      @(posedge clk); #1;
      n++;
      drv(sel, 1'b0, a, b, cin, sub);
    end
    os = sel ? if16.sum : {8'h00, if8.sum};
    oc = sel ? if16.cout : if8.cout;
    ov = sel ? if16.ovf : if8.ovf;
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_busy_run"}, 64'(bz), 64'd1);
    chk({tag, "_sum_held"}, 64'(held), 64'd1);
    chk({tag, "_busy_done"}, 64'(sel ? if16.busy : if8.busy), 64'd0);
    chk({tag, "_sum"}, 64'(os), 64'(es));
    chk({tag, "_cout"}, 64'(oc), 64'(ec));
    chk({tag, "_ovf"}, 64'(ov), 64'(eo));
  endtask

  task automatic done_drops(input bit sel, input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(sel ? if16.done : if8.done), 64'd0);
  endtask

  initial begin
    logic [15:0] s, ra, rb;
    logic        co, ov;
    bit          seen, rsub, rcin;
    rst8 = 1'b1;
    rst16 = 1'b1;
    drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drv(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst16 = 1'b0;
    chk("rst_busy", 64'(if8.busy), 64'd0);
    chk("rst_done", 64'(if8.done), 64'd0);
    chk("rst_sum", 64'(if8.sum), 64'd0);
    chk("rst_cout", 64'(if8.cout), 64'd0);
    chk("rst_ovf", 64'(if8.ovf), 64'd0);
    chk("rst16_sum", 64'(if16.sum), 64'd0);

    op(1'b0, 16'h0F, 16'h01, 1'b0, 1'b0, 0, "add0f", s, co, ov);
    chk("add0f_lit", 64'({s[7:0], co, ov}), 64'({8'h10, 1'b0, 1'b0}));
    done_drops(1'b0, "add0f");
    op(1'b0, 16'h7F, 16'h01, 1'b0, 1'b0, 0, "add7f", s, co, ov);
    chk("add7f_lit", 64'({s[7:0], co, ov}), 64'({8'h80, 1'b0, 1'b1}));
    done_drops(1'b0, "add7f");
    op(1'b0, 16'hFF, 16'h01, 1'b0, 1'b0, 0, "addff", s, co, ov);
    chk("addff_lit", 64'({s[7:0], co, ov}), 64'({8'h00, 1'b1, 1'b0}));
    done_drops(1'b0, "addff");
    op(1'b0, 16'h05, 16'h07, 1'b0, 1'b1, 0, "sub57", s, co, ov);
    chk("sub57_lit", 64'({s[7:0], co, ov}), 64'({8'hFE, 1'b0, 1'b0}));
    done_drops(1'b0, "sub57");
    op(1'b0, 16'h80, 16'h01, 1'b0, 1'b1, 0, "sub80", s, co, ov);
    chk("sub80_lit", 64'({s[7:0], co, ov}), 64'({8'h7F, 1'b1, 1'b1}));
    done_drops(1'b0, "sub80");

    op(1'b0, 16'h12, 16'h34, 1'b0, 1'b0, 3, "poke", s, co, ov);
    chk("poke_lit", 64'(s[7:0]), 64'h46);
    op(1'b0, 16'h21, 16'h10, 1'b1, 1'b0, 0, "b2b", s, co, ov);
    chk("b2b_lit", 64'(s[7:0]), 64'h32);
    done_drops(1'b0, "b2b");

    drv(1'b0, 1'b1, 16'h33, 16'h44, 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(1'b0, 1'b0, 16'h33, 16'h44, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk("abort_busy", 64'(if8.busy), 64'd0);
    chk("abort_done", 64'(if8.done), 64'd0);
    chk("abort_sum", 64'(if8.sum), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) seen = 1'b1;
    end
    chk("abort_quiet", 64'(seen), 64'd0);

    op(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, "w16", s, co, ov);
    chk("w16_lit", 64'({s, co}), 64'({16'h0001, 1'b1}));
    done_drops(1'b1, "w16");

    for (int i = 0; i < 20; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rsub = 1'($urandom);
      rcin = 1'($urandom);
      op(1'b1, ra, rb, rcin, rsub, 0, "rnd16", s, co, ov);
    end
    done_drops(1'b1, "rnd16");
    for (int i = 0; i < 20; i++) begin
      ra   = {8'h00, 8'($urandom)};
      rb   = {8'h00, 8'($urandom)};
      rsub = 1'($urandom);
      rcin = 1'($urandom);
      op(1'b0, ra, rb, rcin, rsub, 0, "rnd8", s, co, ov);
    end
    done_drops(1'b0, "rnd8");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised multi-cycle adder/subtractor: loads two WIDTH-bit operands on a start pulse and produces the sum DIGIT bits per clock through a ripple chain of full-adder cells, with a registered carry between digits. It is the sequential, width-generalised successor to the single-bit full adder and serves as the arithmetic building block for area-constrained datapaths in the course designs. It adds a start/busy/done handshake, subtract mode, carry-out and signed-overflow flags.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH evenly (elaboration error otherwise).
- Derived: STEPS = WIDTH/DIGIT.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b+cin, 1 = a−b (cin ignored); sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in for add mode, sampled with start.
- busy  out  1  high throughout RUN.
- done  out  1  single-cycle pulse: results valid.
- sum  out  WIDTH  result, held from done until the next accepted start.
- cout  out  1  unsigned carry out of the MSB.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b' = sub ? ~b : b, carry = sub ? 1 : cin; clear the step counter; go to RUN.
- RUN: each cycle add the low DIGIT bits of A and b' plus the carry register through the cell chain. Shift A and b' right by DIGIT. Shift the digit sum into sum from the MSB end. Update the carry register and increment the counter. On the step with counter = STEPS−1, capture cout and ovf and go to DONE.
- DONE: done=1 for this cycle only, then go to IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
- start during RUN is ignored: no latch, no restart, no error flag.
- sum, cout and ovf are not modified in RUN until the final step. They show the previous result (or reset values) until done.
- Width rules: internal carry is 1 bit. The counter is sized to hold STEPS−1. All arithmetic is modulo 2^WIDTH.
- rst=1 in any state (including mid-RUN) aborts the operation and returns to IDLE at that edge, with no done pulse.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, counter=0.
- start accepted at edge E0 → busy=1 from E0 through the edge completing the final step.
- Latency: done is high in the cycle following edge E0+STEPS, i.e. STEPS+1 cycles after start was sampled. Example: WIDTH=8, DIGIT=1 gives done 9 cycles after start; DIGIT=4 gives 3 cycles.
- Throughput: one operation per STEPS+1 cycles with back-to-back starts in DONE.
- busy and done are never high in the same cycle.

## Structure
- Shared package adder_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a function computing counter width from STEPS.
- Sub-module fa_cell: one-bit full adder with ports (a, b, ci, s, co). DIGIT instances are chained by generate into the per-cycle ripple slice. The carry into the last cell is exported for ovf.
- Top contains the FSM, operand shift registers, carry register, counter and result register.

## Test plan
- WIDTH=8, DIGIT=1, add a=0x0F, b=0x01, cin=0 → sum=0x10, cout=0, ovf=0; done exactly 9 cycles after start, for one cycle.
- Add a=0x7F, b=0x01 → sum=0x80, ovf=1, cout=0. Add a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0.
- Subtract a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0. Subtract a=0x80, b=0x01 → sum=0x7F, ovf=1, cout=1.
- start with new operands during RUN → ignored; the first result completes unchanged. start in the DONE cycle → second result arrives 9 cycles later.
- rst asserted at step 4 of RUN → next cycle busy=0, done=0, sum=0, state IDLE; no done pulse afterwards until a new start.
- Repeat with WIDTH=16, DIGIT=4, a=0xFFFF, b=0x0001, cin=1 → sum=0x0001, cout=1; done 5 cycles after start. Then sweep random operands against the a+b+cin reference model.
